// File: rtl/fsm_ksa_shuffler_if.sv
// Controller handshake and working-RAM port bundle for the RC4 key-scheduling stage.
// The master side is the controller plus RAM; the slave side is the shuffler.
interface fsm_ksa_shuffler_if;
  logic        start;
  logic        finish_ack;
  logic [23:0] secret_key;
  logic [7:0]  q_S;
  logic [7:0]  Address_S;
  logic [7:0]  data_S;
  logic        wren_S;
  logic        busy;
  logic        finish;

  modport master (
    output start, finish_ack, secret_key, q_S,
    input  Address_S, data_S, wren_S, busy, finish
  );

  modport slave (
    input  start, finish_ack, secret_key, q_S,
    output Address_S, data_S, wren_S, busy, finish
  );
endinterface

// File: rtl/fsm_ksa_shuffler.sv
// RC4 key-scheduling stage: optional identity fill of S, then the 256-step KSA swap loop.
// Define KSA_INIT_FILL_EN to build in the S[i]=i fill phase ahead of the swap loop.
module fsm_ksa_shuffler (
  input logic              clk,
  input logic              rst_n,
  fsm_ksa_shuffler_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FILL    = 4'd1,
    RD_I    = 4'd2,
    WT_I    = 4'd3,
    CALC_J  = 4'd4,
    RD_J    = 4'd5,
    WT_J    = 4'd6,
    WR_I    = 4'd7,
    WR_I_EN = 4'd8,
    WR_J    = 4'd9,
    WR_J_EN = 4'd10,
    NEXT    = 4'd11,
    DONE    = 4'd12
  } state_t;

  state_t      state;
  logic [7:0]  i, j, si, sj;
  logic [1:0]  kidx;
  logic [23:0] key_r;
  logic [7:0]  key_byte;
  logic [7:0]  addr_r, data_r;
  logic        busy_r, finish_r;

  always_comb begin
    case (kidx)
      2'd0:    key_byte = key_r[23:16];
      2'd1:    key_byte = key_r[15:8];
      default: key_byte = key_r[7:0];
    endcase
  end

  // Decoded straight from state so an async reset drops the strobe at once.
  assign bus.wren_S    = (state == FILL) || (state == WR_I_EN) || (state == WR_J_EN);
  assign bus.Address_S = addr_r;
  assign bus.data_S    = data_r;
  assign bus.busy      = busy_r;
  assign bus.finish    = finish_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      i        <= 8'd0;
      j        <= 8'd0;
      si       <= 8'd0;
      sj       <= 8'd0;
      kidx     <= 2'd0;
      key_r    <= 24'd0;
      addr_r   <= 8'd0;
      data_r   <= 8'd0;
      busy_r   <= 1'b0;
      finish_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            key_r  <= bus.secret_key;
            i      <= 8'd0;
            j      <= 8'd0;
            si     <= 8'd0;
            sj     <= 8'd0;
            kidx   <= 2'd0;
            addr_r <= 8'd0;
            data_r <= 8'd0;
            busy_r <= 1'b1;
`ifdef KSA_INIT_FILL_EN
            state  <= FILL;
`else
            state  <= RD_I;
`endif
          end
        end
`ifdef KSA_INIT_FILL_EN
        // Address/data run one ahead of i so each FILL cycle presents S[i]=i.
        FILL: begin
          if (i == 8'hFF) begin
            i     <= 8'd0;
            state <= RD_I;
          end else begin
            i      <= i + 8'd1;
            addr_r <= i + 8'd1;
            data_r <= i + 8'd1;
          end
        end
`endif
        RD_I: begin
          addr_r <= i;
          state  <= WT_I;
        end
        WT_I:   state <= CALC_J;
        CALC_J: begin
          si    <= bus.q_S;
          j     <= j + bus.q_S + key_byte;
          state <= RD_J;
        end
        RD_J: begin
          addr_r <= j;
          state  <= WT_J;
        end
        WT_J:   state <= WR_I;
        WR_I: begin
          sj     <= bus.q_S;
          addr_r <= i;
          data_r <= bus.q_S;
          state  <= WR_I_EN;
        end
        WR_I_EN: begin
          data_r <= sj;
          state  <= WR_J;
        end
        // When i==j this rewrites the same address with si, which is the right final value.
        WR_J: begin
          addr_r <= j;
          data_r <= si;
          state  <= WR_J_EN;
        end
        WR_J_EN: state <= NEXT;
        NEXT: begin
          if (i == 8'hFF) begin
            finish_r <= 1'b1;
            state    <= DONE;
          end else begin
            i     <= i + 8'd1;
            kidx  <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
            state <= RD_I;
          end
        end
        DONE: begin
          if (bus.finish_ack) begin
            finish_r <= 1'b0;
            busy_r   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          finish_r <= 1'b0;
          busy_r   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_ksa_shuffler.sv
// Directed bench for fsm_ksa_shuffler: RAM model, software KSA reference and write-log vectors.
module tb_fsm_ksa_shuffler;
`ifdef KSA_INIT_FILL_EN
  localparam int FILL_N = 256;
`else
  localparam int FILL_N = 0;
`endif
  localparam int RUN_CYC = 2560 + FILL_N;

  typedef struct { logic [23:0] key; int kind; int poke; } run_vec_t;
  typedef struct { int run; int wi; logic [7:0] a; logic [7:0] d; } wr_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fsm_ksa_shuffler_if bus();
  fsm_ksa_shuffler dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] mem    [256];
  logic [7:0] ld_mem [256];
  logic [7:0] model_s[256];
  logic [7:0] log_a  [4096];
  logic [7:0] log_d  [4096];
  logic       ld = 1'b0;
  int         wr_cnt;
  int         n_tests = 0;
  int         n_fail = 0;

  // Synchronous-read RAM; every write is also appended to the log.
  always @(posedge clk) begin
    if (ld) begin
      for (int k = 0; k < 256; k++) mem[k] <= ld_mem[k];
      wr_cnt <= 0;
    end else if (bus.wren_S === 1'b1) begin
      mem[bus.Address_S] <= bus.data_S;
      if (wr_cnt < 4096) begin
        log_a[wr_cnt] <= bus.Address_S;
        log_d[wr_cnt] <= bus.data_S;
      end
      wr_cnt <= wr_cnt + 1;
    end
    bus.q_S <= mem[bus.Address_S];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_ram(input int kind);
    for (int k = 0; k < 256; k++) ld_mem[k] = k[7:0];
    if (kind == 1) begin
      ld_mem[0] = 8'h01;
      ld_mem[1] = 8'h00;
    end
    @(negedge clk) ld = 1'b1;
    @(negedge clk) ld = 1'b0;
  endtask

  task automatic model_ksa(input logic [23:0] key, input int kind);
    int j;
    logic [7:0] t, kb;
    for (int k = 0; k < 256; k++) model_s[k] = k[7:0];
    if (kind == 1 && FILL_N == 0) begin
      model_s[0] = 8'h01;
      model_s[1] = 8'h00;
    end
    j = 0;
    for (int i = 0; i < 256; i++) begin
      case (i % 3)
        0:       kb = key[23:16];
        1:       kb = key[15:8];
        default: kb = key[7:0];
      endcase
      j = (j + int'(model_s[i]) + int'(kb)) % 256;
      t = model_s[i];
      model_s[i] = model_s[j];
      model_s[j] = t;
    end
  endtask

  task automatic chk_ram(input string name);
    int bad, first;
    bad = 0;
    first = 0;
    for (int k = 0; k < 256; k++)
      if (mem[k] !== model_s[k]) begin
        if (bad == 0) first = k;
        bad++;
      end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d bytes differ, first S[%0d] got %0h expected %0h",
               name, bad, first, mem[first], model_s[first]);
    end
  endtask

  // Returns the number of edges after the start-sampling edge until finish is seen.
  task automatic run_ksa(input logic [23:0] key, input int poke_at, output int cyc);
    @(negedge clk);
    bus.secret_key = key;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
    while (bus.finish !== 1'b1 && cyc < RUN_CYC + 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == poke_at) begin
        bus.start = 1'b1;
        bus.secret_key = 24'hABCDEF;
      end else begin
        bus.start = 1'b0;
      end
    end
  endtask

  task automatic ack_finish(input string name);
    @(negedge clk) bus.finish_ack = 1'b1;
    @(posedge clk); #1;
    bus.finish_ack = 1'b0;
    chk({name, " finish after ack"}, bus.finish, 0);
    chk({name, " busy after ack"}, bus.busy, 0);
  endtask

  initial begin
    run_vec_t runs[5];
    wr_vec_t  wv[10];
    int cyc, hold_bad, w0;

    bus.start = 1'b0;
    bus.finish_ack = 1'b0;
    bus.secret_key = 24'd0;

    runs[0] = '{24'h010203, 0, 0};
    runs[1] = '{24'hFF0000, 0, 0};
    runs[2] = '{24'h000249, 0, 0};
    runs[3] = '{24'hFFFFFF, 0, 700};
`ifdef KSA_INIT_FILL_EN
    runs[4] = '{24'h000000, 0, 0};
`else
    runs[4] = '{24'hFF0000, 1, 0};
`endif
    wv[0] = '{0, 0, 8'h00, 8'h01};
    wv[1] = '{0, 1, 8'h01, 8'h00};
    wv[2] = '{0, 2, 8'h01, 8'h03};
    wv[3] = '{0, 3, 8'h03, 8'h00};
    wv[4] = '{1, 0, 8'h00, 8'hFF};
    wv[5] = '{1, 1, 8'hFF, 8'h00};
    wv[6] = '{1, 2, 8'h01, 8'hFF};
    wv[7] = '{1, 3, 8'h00, 8'h01};
`ifdef KSA_INIT_FILL_EN
    wv[8] = '{4, 0, 8'h00, 8'h00};
    wv[9] = '{4, 1, 8'h00, 8'h00};
`else
    wv[8] = '{4, 0, 8'h00, 8'h01};
    wv[9] = '{4, 1, 8'h00, 8'h01};
`endif

    #1;
    chk("reset Address_S", bus.Address_S, 0);
    chk("reset data_S", bus.data_S, 0);
    chk("reset wren_S", bus.wren_S, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset finish", bus.finish, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int r = 0; r < 5; r++) begin
      load_ram(runs[r].kind);
      model_ksa(runs[r].key, runs[r].kind);
      run_ksa(runs[r].key, runs[r].poke, cyc);
      chk($sformatf("run%0d cycles", r), cyc, RUN_CYC);
      chk_ram($sformatf("run%0d final S", r));
      for (int v = 0; v < 10; v++)
        if (wv[v].run == r) begin
          chk($sformatf("run%0d wr%0d addr", r, wv[v].wi), log_a[FILL_N + wv[v].wi], wv[v].a);
          chk($sformatf("run%0d wr%0d data", r, wv[v].wi), log_d[FILL_N + wv[v].wi], wv[v].d);
        end
`ifdef KSA_INIT_FILL_EN
      if (r == 0) begin
        hold_bad = 0;
        for (int n = 0; n < 256; n++)
          if (log_a[n] !== n[7:0] || log_d[n] !== n[7:0]) hold_bad++;
        chk("fill writes", hold_bad, 0);
      end
`endif
      w0 = wr_cnt;
      hold_bad = 0;
      repeat (50) begin
        @(posedge clk); #1;
        if (bus.finish !== 1'b1 || bus.busy !== 1'b1 || bus.wren_S !== 1'b0) hold_bad++;
      end
      chk($sformatf("run%0d DONE hold", r), hold_bad, 0);
      chk($sformatf("run%0d DONE writes", r), wr_cnt - w0, 0);
      ack_finish($sformatf("run%0d", r));
    end

    // Reset during the WR_J_EN cycle of iteration 5, then a clean rerun.
    load_ram(0);
    @(negedge clk);
    bus.secret_key = 24'h5A3C11;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
    while (!(bus.wren_S === 1'b1 && wr_cnt == FILL_N + 11) && cyc < RUN_CYC) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("reached WR_J_EN", bus.wren_S, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset wren_S", bus.wren_S, 0);
    chk("midreset Address_S", bus.Address_S, 0);
    chk("midreset data_S", bus.data_S, 0);
    chk("midreset busy", bus.busy, 0);
    chk("midreset finish", bus.finish, 0);
    @(negedge clk) rst_n = 1'b1;

    load_ram(0);
    model_ksa(24'h5A3C11, 0);
    run_ksa(24'h5A3C11, 0, cyc);
    chk("rerun cycles", cyc, RUN_CYC);
    chk_ram("rerun final S");
    ack_finish("rerun");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
